ram_dump_uart: RTL and testbench
================================

// Module: ram_dump_uart
// PURPOSE
//  Reads RAM out; the reverse of the bootloader, which writes programs in. When started, it takes
//  the RAM address lines, walks addresses 0..DEPTH-1 and samples each byte. Each frame goes out
//  on a UART 8N1 TX line for host-side inspection. Runs on the system clock while the CPU is halted.
// PARAMETERS
//  CLKS_PER_BIT  234    sys clocks per UART bit (27 MHz / 115200); legal range 2..65535
//  DEPTH         16     number of RAM bytes dumped, addresses 0..DEPTH-1 (DEPTH <= 2**ADDR_W)
//  ADDR_W        4      RAM address width
//  SYNC_BYTE     8'hA5  header byte sent before the first RAM byte
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       pulse or level; sampled only in IDLE
//  ram_data      in   8       RAM read data, valid 1 cycle after dump_addr changes
//  dump_addr     out  ADDR_W  RAM address driven while dump_active
//  dump_active   out  1       high from leaving IDLE until return to IDLE; top muxes dump_addr into RAM
//  busy          out  1       identical to dump_active
//  done          out  1       1-cycle pulse on the cycle the FSM returns to IDLE after the last stop bit
//  tx            out  1       UART serial output, idle high
// BEHAVIOUR
//  Reset values (async, immediate on rst=1)
//   - state=IDLE, tx=1, dump_addr=0, dump_active=0, busy=0, done=0
//   - shift register=0, bit counter=0, baud counter=0
//  Frame format
//   - start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly CLKS_PER_BIT cycles
//   - baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 at each bit boundary
//  FSM states
//   - IDLE: tx=1. start=1 -> load shift reg with SYNC_BYTE, set hdr flag, dump_addr=0, go START.
//   - START: tx=0 for CLKS_PER_BIT cycles -> DATA with bit counter 0.
//   - DATA: tx=shift[0]. Every CLKS_PER_BIT cycles shift right and increment bit counter.
//     After bit 7 -> STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles.
//     If hdr flag set: clear it, go FETCH; dump_addr stays 0.
//     Else if dump_addr==DEPTH-1: assert done for 1 cycle and go IDLE.
//     Else: dump_addr+1, go FETCH.
//   - FETCH: 1 cycle so the new address settles -> LATCH.
//   - LATCH: shift reg <= ram_data; go START.
//  Timing and latency
//   - start high in IDLE at edge N: tx falls at edge N+1.
//   - Inter-frame gap after a stop bit is exactly 2 cycles of tx=1 (FETCH and LATCH).
//   - Total dump length = (DEPTH+1)*10*CLKS_PER_BIT + 2*DEPTH cycles.
//  Boundary rules
//   - start while busy is ignored; no restart or queueing.
//   - start held high continuously -> a new dump begins the cycle after done.
//   - dump_addr never exceeds DEPTH-1 and does not wrap during a dump. It holds its last value in
//     IDLE; dump_active=0 makes this harmless.
//   - ram_data is sampled only in LATCH. Changes at any other time have no effect.
//   - rst mid-frame: tx returns to 1 immediately, the partial frame is abandoned and no done is
//     issued. The host sees a framing error, which is acceptable.
//   - DEPTH=1: sync byte, then byte 0, then done.
// TESTING
//  Benches use CLKS_PER_BIT=4 and DEPTH=16.
//  1. Header frame: RAM preloaded 0x00..0x0F, start pulse at cycle 10.
//     -> tx=0 at cycle 11; decoded stream A5,00,01,...,0F; done pulse once; busy low after it.
//  2. Bit timing: RAM[0]=0x81.
//     -> second frame reads 0,1,0,0,0,0,0,0,1,1, each held 4 cycles; 2 idle-high cycles precede it.
//  3. Start while busy: pulse start again mid-dump at byte 5.
//     -> exactly 17 frames total; dump_addr sequence 0..15 unchanged.
//  4. Reset mid-frame: assert rst during DATA of byte 3.
//     -> tx=1, busy=0, dump_addr=0 the same cycle, no done. A new start then gives the full
//        17-frame dump from A5.
//  5. Continuous start: hold start high.
//     -> second dump's start bit begins the cycle after done; two complete dumps are seen.
//  6. Data sampling: change ram_data outside LATCH (glitch 0xFF while in START).
//     -> transmitted byte equals the value present in LATCH, not 0xFF.

Source files
------------

// File: rtl/ram_dump_uart.sv
// RAM dump engine: walks RAM addresses 0..DEPTH-1 and sends a sync byte followed by
// every RAM byte as UART 8N1 frames on tx, for host-side inspection while the CPU is halted.
module ram_dump_uart #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        ram_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_active,
  output logic              busy,
  output logic              done,
  output logic              tx
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, FETCH, LATCH} state_t;

  state_t            state, state_nx;
  logic [15:0]       baud_cnt, baud_nx;
  logic [2:0]        bit_cnt, bit_nx;
  logic [7:0]        shift, shift_nx;
  logic              hdr, hdr_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              done_nx, tx_nx;
  logic              bit_end, last_addr;

  always_comb begin
    state_nx  = state;
    baud_nx   = '0;
    bit_nx    = bit_cnt;
    shift_nx  = shift;
    hdr_nx    = hdr;
    addr_nx   = dump_addr;
    done_nx   = 1'b0;
    bit_end   = (baud_cnt == 16'(CLKS_PER_BIT - 1));
    last_addr = (dump_addr == ADDR_W'(DEPTH - 1));

    if (state inside {START, DATA, STOP})
      baud_nx = bit_end ? '0 : baud_cnt + 16'd1;

    case (state)
      IDLE: if (start) begin
        shift_nx = SYNC_BYTE;
        hdr_nx   = 1'b1;
        addr_nx  = '0;
        bit_nx   = '0;
        state_nx = START;
      end
      START: if (bit_end) begin
        bit_nx   = '0;
        state_nx = DATA;
      end
      DATA: if (bit_end) begin
        shift_nx = {1'b0, shift[7:1]};
        bit_nx   = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nx = STOP;
      end
      STOP: if (bit_end) begin
        if (hdr) begin
          hdr_nx   = 1'b0;
          state_nx = FETCH;
        end else if (last_addr) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          addr_nx  = dump_addr + ADDR_W'(1);
          state_nx = FETCH;
        end
      end
      FETCH: state_nx = LATCH;
      LATCH: begin
        shift_nx = ram_data;
        state_nx = START;
      end
      default: state_nx = IDLE;
    endcase

    // tx is registered from the next-state view so the line changes on the same edge as the state
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      hdr         <= 1'b0;
      dump_addr   <= '0;
      dump_active <= 1'b0;
      done        <= 1'b0;
      tx          <= 1'b1;
    end else begin
      state       <= state_nx;
      baud_cnt    <= baud_nx;
      bit_cnt     <= bit_nx;
      shift       <= shift_nx;
      hdr         <= hdr_nx;
      dump_addr   <= addr_nx;
      dump_active <= (state_nx != IDLE);
      done        <= done_nx;
      tx          <= tx_nx;
    end
  end

  always_comb busy = dump_active;

endmodule

// File: tb/tb_ram_dump_uart.sv
// Bench for ram_dump_uart: cycle-exact tx/busy/done/address waveform built from the frame rules,
// driven by a table of dump scenarios plus hand-written reset and bit-timing sequences.
module tb_ram_dump_uart;
  localparam int unsigned C     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    ram_data, ram_q;
  logic [AW-1:0] dump_addr;
  logic          dump_active, busy, done, tx;
  logic [7:0]    ram [DEPTH];
  logic          glitch_on = 1'b0;
  int            checks = 0;
  int            failures = 0;

  typedef struct {
    int kind;       // 0: ram[i]=i, 1: random with ram[0]=0x81, 2: random
    bit glitch;     // drive 0xFF on ram_data whenever tx is low
    int restart;    // cycle index of an extra start pulse while busy (-1: none)
    int n_dumps;
    bit hold;       // keep start high for the whole run
    int exp_busy;   // expected number of busy-high cycles
    bit bitchk;     // check the second frame bit by bit
    bit rst_first;  // abort a dump with rst before this run
  } vec_t;

  ram_dump_uart #(.CLKS_PER_BIT(C), .DEPTH(DEPTH), .ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .ram_data(ram_data), .dump_addr(dump_addr),
    .dump_active(dump_active), .busy(busy), .done(done), .tx(tx)
  );

  always #5 clk = ~clk;

  // synchronous-read RAM: data follows the address one cycle later
  always @(posedge clk) ram_q <= ram[dump_addr];
  assign ram_data = (glitch_on && !tx) ? 8'hFF : ram_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0]    exp_q[$];
    logic          cap[$];
    logic [7:0]    b;
    logic [AW-1:0] a;
    logic          bitv;
    logic [9:0]    eb;
    int            busy_cyc;
    busy_cyc = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = (v.kind == 0) ? 8'(i) : 8'($urandom);
    if (v.kind == 1) ram[0] = 8'h81;
    glitch_on = v.glitch;

    // expected per-cycle {tx, busy, dump_active, done, dump_addr}
    for (int d = 0; d < v.n_dumps; d++) begin
      for (int f = 0; f <= DEPTH; f++) begin
        b = (f == 0) ? 8'hA5 : ram[f-1];
        a = (f == 0) ? '0 : AW'(f - 1);
        for (int k = 0; k < 10; k++) begin
          bitv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
          repeat (C) exp_q.push_back({bitv, 1'b1, 1'b1, 1'b0, a});
        end
        if (f < DEPTH) repeat (2) exp_q.push_back({1'b1, 1'b1, 1'b1, 1'b0, AW'(f)});
      end
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, AW'(DEPTH - 1)});
    end

    @(negedge clk); start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("v%0d_cyc%0d", id, i),
            32'({tx, busy, dump_active, done, dump_addr}), 32'(exp_q[i]));
      cap.push_back(tx);
      if (busy) busy_cyc++;
      start = (v.hold && i < exp_q.size() - 1) || (i == v.restart);
    end
    start = 1'b0;
    check($sformatf("v%0d_busy_cycles", id), 32'(busy_cyc), 32'(v.exp_busy));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_idle%0d", id, i), 32'({tx, busy, done}), 32'(3'b100));
    end

    if (v.bitchk) begin
      eb = 10'b1100000010;
      check($sformatf("v%0d_gap", id), 32'({cap[40], cap[41]}), 32'(2'b11));
      for (int j = 0; j < 10; j++)
        check($sformatf("v%0d_frame1_bit%0d", id, j),
              32'({cap[42+4*j], cap[43+4*j], cap[44+4*j], cap[45+4*j]}), 32'({4{eb[j]}}));
    end
  endtask

  task automatic reset_mid_frame();
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
    ram[3] = 8'h00;
    glitch_on = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (177) @(negedge clk);
    check("pre_rst_data_byte3", 32'({tx, busy, dump_addr}), 32'({1'b0, 1'b1, 4'd3}));
    rst = 1'b1;
    #1;
    check("rst_immediate", 32'({tx, busy, dump_active, done, dump_addr}), 32'(8'b1000_0000));
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy || !tx) bad = 1'b1;
    end
    check("post_rst_quiet", 32'(bad), 32'(0));
  endtask

  initial begin
    vec_t vecs[5];
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    #1 rst = 1'b1;
    #1 check("reset_state", 32'({tx, busy, dump_active, done, dump_addr}), 32'(8'b1000_0000));
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);

    vecs[0] = '{0, 1'b0,  -1, 1, 1'b0,  712, 1'b0, 1'b0};
    vecs[1] = '{1, 1'b1,  -1, 1, 1'b0,  712, 1'b1, 1'b0};
    vecs[2] = '{2, 1'b1, 262, 1, 1'b0,  712, 1'b0, 1'b0};
    vecs[3] = '{2, 1'b0,  -1, 2, 1'b1, 1424, 1'b0, 1'b0};
    vecs[4] = '{2, 1'b0,  -1, 1, 1'b0,  712, 1'b0, 1'b1};

    for (int n = 0; n < 5; n++) begin
      if (vecs[n].rst_first) reset_mid_frame();
      run_vec(vecs[n], n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
